// File: rtl/ext_mem_bridge_if.sv
// ext_mem_bridge_if: reqrsp request/response channel between a requester and
// the external memory bridge.
//   q_* : request  (valid/ready, byte address, write flag, write data, strobes)
//   p_* : response (valid/ready, read data, error flag)
// Modports: master drives requests, slave drives responses.
interface ext_mem_bridge_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) ();
  logic                    q_valid;
  logic                    q_ready;
  logic [ADDR_WIDTH-1:0]   q_addr;
  logic                    q_write;
  logic [DATA_WIDTH-1:0]   q_data;
  logic [DATA_WIDTH/8-1:0] q_strb;
  logic                    p_valid;
  logic                    p_ready;
  logic [DATA_WIDTH-1:0]   p_data;
  logic                    p_error;

  modport master (
    output q_valid, q_addr, q_write, q_data, q_strb, p_ready,
    input  q_ready, p_valid, p_data, p_error
  );

  modport slave (
    input  q_valid, q_addr, q_write, q_data, q_strb, p_ready,
    output q_ready, p_valid, p_data, p_error
  );
endinterface

// File: rtl/ext_mem_bridge.sv
// ext_mem_bridge: reqrsp slave port to NUM_BANKS word-interleaved SRAM banks.
// Requests inside [BASE_ADDR, BASE_ADDR+MEM_SIZE) are issued to the selected
// bank in the acceptance cycle; out-of-range requests return an error response.
// Responses flow through a RD_LATENCY-deep tracking pipeline into a
// first-word fall-through FIFO; acceptance is credit-limited so the FIFO can
// never overflow.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   bus            : reqrsp slave (ext_mem_bridge_if.slave)
//   mem_en_o       : per-bank enable (one-hot or zero)
//   mem_we_o       : write enable
//   mem_be_o       : byte enables (all-ones for reads)
//   mem_addr_o     : word address within a bank
//   mem_wdata_o    : write data
//   mem_rdata_i    : read data, bank k at slice k
// Optional (macro SOPHON_EXT_MEM_STAT_EN): stat_rd_o, stat_wr_o, stat_err_o
// saturating counters of accepted reads, writes and out-of-range accesses.
module ext_mem_bridge #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_1000,
  parameter logic [ADDR_WIDTH-1:0] MEM_SIZE   = 32'h0002_0000,
  parameter int unsigned           NUM_BANKS  = 2,
  parameter int unsigned           RD_LATENCY = 1,
  parameter int unsigned           RSP_DEPTH  = 2,
  localparam int unsigned          BYTES      = DATA_WIDTH / 8,
  localparam int unsigned          BW         = $clog2(MEM_SIZE / (NUM_BANKS * BYTES))
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  ext_mem_bridge_if.slave                 bus,
  output logic [NUM_BANKS-1:0]            mem_en_o,
  output logic                            mem_we_o,
  output logic [BYTES-1:0]                mem_be_o,
  output logic [BW-1:0]                   mem_addr_o,
  output logic [DATA_WIDTH-1:0]           mem_wdata_o,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] mem_rdata_i
`ifdef SOPHON_EXT_MEM_STAT_EN
  ,
  output logic [31:0]                     stat_rd_o,
  output logic [31:0]                     stat_wr_o,
  output logic [15:0]                     stat_err_o
`endif
);

  localparam int unsigned OFF_BITS  = $clog2(BYTES);
  localparam int unsigned BANK_BITS = $clog2(NUM_BANKS);
  localparam int unsigned BIW       = (NUM_BANKS > 1) ? BANK_BITS : 1;
  localparam int unsigned PW        = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CW        = $clog2(RSP_DEPTH + RD_LATENCY + 1) + 1;
  localparam int unsigned LAST      = RD_LATENCY - 1;

  // Held low through reset so no request is taken before the first clock.
  logic ready_en_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ready_en_q <= 1'b0;
    else         ready_en_q <= 1'b1;
  end

  // ---------------- Address decode ----------------
  logic [ADDR_WIDTH-1:0] off;
  logic [ADDR_WIDTH-1:0] word;
  logic                  in_range;
  logic [BIW-1:0]        bank;

  assign off      = bus.q_addr - BASE_ADDR;
  assign in_range = (bus.q_addr >= BASE_ADDR) && (off < MEM_SIZE);
  assign word     = off >> OFF_BITS;
  assign bank     = BIW'(word % NUM_BANKS);

  // ---------------- Credit / acceptance ----------------
  logic [RD_LATENCY-1:0] stg_vld_q;
  logic [RD_LATENCY-1:0] stg_we_q;
  logic [RD_LATENCY-1:0] stg_err_q;
  logic [BIW-1:0]        stg_bank_q [RD_LATENCY];

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] inflight;
  logic [CW-1:0] used;
  logic          q_ready;
  logic          accept;
  logic          push;
  logic          pop;
  logic          p_valid;

  assign p_valid = (cnt_q != '0);
  assign pop     = p_valid && bus.p_ready;
  assign push    = stg_vld_q[LAST];

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CW'(stg_vld_q[i]);
    end
  end

  // A pop in this cycle frees its slot immediately.
  assign used    = inflight + cnt_q - CW'(pop);
  assign q_ready = ready_en_q && (used < CW'(RSP_DEPTH));
  assign accept  = bus.q_valid && q_ready;

  assign bus.q_ready = q_ready;

  // ---------------- Memory issue ----------------
  assign mem_en_o    = (accept && in_range) ? (NUM_BANKS'(1) << bank) : '0;
  assign mem_we_o    = bus.q_write;
  assign mem_be_o    = bus.q_write ? bus.q_strb : '1;
  assign mem_addr_o  = BW'(word >> BANK_BITS);
  assign mem_wdata_o = bus.q_data;

  // ---------------- Tracking pipeline ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stg_vld_q <= '0;
      stg_we_q  <= '0;
      stg_err_q <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        stg_bank_q[i] <= '0;
      end
    end else begin
      stg_vld_q[0]  <= accept;
      stg_we_q[0]   <= bus.q_write;
      stg_err_q[0]  <= !in_range;
      stg_bank_q[0] <= bank;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        stg_vld_q[i]  <= stg_vld_q[i-1];
        stg_we_q[i]   <= stg_we_q[i-1];
        stg_err_q[i]  <= stg_err_q[i-1];
        stg_bank_q[i] <= stg_bank_q[i-1];
      end
    end
  end

  logic [DATA_WIDTH-1:0] push_data;

  assign push_data = (stg_we_q[LAST] || stg_err_q[LAST]) ? '0
                   : mem_rdata_i[stg_bank_q[LAST]*DATA_WIDTH +: DATA_WIDTH];

  // ---------------- Response FIFO (first-word fall-through) ----------------
  logic [DATA_WIDTH-1:0] fifo_data_q [RSP_DEPTH];
  logic                  fifo_err_q  [RSP_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [PW-1:0]         wr_ptr_nxt, rd_ptr_nxt;

  assign wr_ptr_nxt = (wr_ptr_q == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
  assign rd_ptr_nxt = (rd_ptr_q == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
  assign cnt_d      = cnt_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_nxt;
      if (pop)  rd_ptr_q <= rd_ptr_nxt;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= push_data;
      fifo_err_q[wr_ptr_q]  <= stg_err_q[LAST];
    end
  end

  assign bus.p_valid = p_valid;
  assign bus.p_data  = p_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign bus.p_error = p_valid ? fifo_err_q[rd_ptr_q] : 1'b0;

`ifdef SOPHON_EXT_MEM_STAT_EN
  // ---------------- Saturating statistics ----------------
  logic [31:0] stat_rd_q;
  logic [31:0] stat_wr_q;
  logic [15:0] stat_err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_rd_q  <= '0;
      stat_wr_q  <= '0;
      stat_err_q <= '0;
    end else if (accept) begin
      if (!bus.q_write && (stat_rd_q != '1)) stat_rd_q  <= stat_rd_q + 32'd1;
      if (bus.q_write && (stat_wr_q != '1))  stat_wr_q  <= stat_wr_q + 32'd1;
      if (!in_range && (stat_err_q != '1))   stat_err_q <= stat_err_q + 16'd1;
    end
  end

  assign stat_rd_o  = stat_rd_q;
  assign stat_wr_o  = stat_wr_q;
  assign stat_err_o = stat_err_q;
`endif

endmodule

// File: doc/ext_mem_bridge.md
Name: ext_mem_bridge

Overview:
- Parametrised bridge from a reqrsp slave port (q request / p response, valid-ready) to N word-interleaved SRAM banks.
- Sits behind the AXI-to-reqrsp conversion on the external instruction/data path, replacing the fixed single-bank, zero-buffer memory adapter.
- Adds:
  - configurable base address, size, bank count and read latency;
  - a response FIFO with credit-based backpressure;
  - error responses for out-of-range accesses.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; power of two, at least 8.
- ADDR_WIDTH, 32, request address width in bits.
- BASE_ADDR, 32'h0000_1000, first byte address served.
- MEM_SIZE, 32'h0002_0000, total bytes served; power of two, multiple of NUM_BANKS*DATA_WIDTH/8.
- NUM_BANKS, 2, number of banks; power of two, 1..8.
- RD_LATENCY, 1, SRAM read latency in cycles, 1..4.
- RSP_DEPTH, 2, response FIFO entries; at least 1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- q_valid_i  in  1  request valid
- q_ready_o  out  1  request ready
- q_addr_i  in  ADDR_WIDTH  byte address
- q_write_i  in  1  1 = write, 0 = read
- q_data_i  in  DATA_WIDTH  write data
- q_strb_i  in  DATA_WIDTH/8  byte strobes
- p_valid_o  out  1  response valid
- p_ready_i  in  1  response ready
- p_data_o  out  DATA_WIDTH  read data; 0 for writes and errors
- p_error_o  out  1  access error
- mem_en_o  out  NUM_BANKS  per-bank enable, one-hot or zero
- mem_we_o  out  1  write enable
- mem_be_o  out  DATA_WIDTH/8  byte enables
- mem_addr_o  out  BW  word address within a bank, BW = log2(MEM_SIZE/(NUM_BANKS*DATA_WIDTH/8))
- mem_wdata_o  out  DATA_WIDTH  write data
- mem_rdata_i  in  NUM_BANKS*DATA_WIDTH  read data, bank k at slice k

Behaviour:
- Clocking and reset:
  - One clock, clk_i.
  - Reset is asynchronous and active-low on rst_ni.
  - Reset values: q_ready_o=0 while rst_ni is low, then 1 from the first cycle after release. p_valid_o=0, p_error_o=0, p_data_o=0, mem_en_o=0.
  - Pipeline, FIFO and credit counter clear on reset.
  - Reset mid-operation drops all in-flight requests and responses silently.
- Acceptance: a request is accepted on a cycle with q_valid_i & q_ready_o.
  - q_ready_o = (inflight + fifo_count) < RSP_DEPTH, where inflight counts pipeline stages holding a valid entry.
  - A same-cycle response pop (p_valid_o & p_ready_i) frees a credit combinationally, so a full FIFO plus a pop accepts a new request.
- Address decode:
  - off = q_addr_i - BASE_ADDR, modulo 2^ADDR_WIDTH.
  - In range iff q_addr_i >= BASE_ADDR and off < MEM_SIZE.
  - word = off >> log2(DATA_WIDTH/8); low byte-offset bits are ignored, with no misalignment error.
  - bank = word mod NUM_BANKS; mem_addr_o = word / NUM_BANKS.
- Memory issue, combinational in the acceptance cycle:
  - In range: mem_en_o[bank]=1. mem_we_o=q_write_i. mem_be_o=q_strb_i, or all-ones for reads. mem_wdata_o=q_data_i.
  - Out of range: no mem_en_o bit set; the entry is still tracked.
  - Idle cycles: mem_en_o=0; other mem_* outputs are don't-care.
- Pipeline:
  - RD_LATENCY stages, each carrying valid, bank index, write flag and error flag.
  - After RD_LATENCY cycles the entry pushes to the FIFO. Read data is taken from mem_rdata_i[bank slice] in that cycle.
  - Writes and errors push data 0.
  - Credit accounting guarantees the FIFO never overflows, so no stall is needed.
- Response FIFO:
  - First-word fall-through.
  - p_valid_o = FIFO not empty.
  - Push and pop in the same cycle keep the count.
  - Responses return strictly in request order.
- Minimum latency: acceptance to p_valid_o is RD_LATENCY+1 cycles.
- Throughput: one request per cycle when RSP_DEPTH >= RD_LATENCY+1 and p_ready_i is held at 1.

Optional Feature:
- Macro: SOPHON_EXT_MEM_STAT_EN.
- When defined, adds three output ports:
  - stat_rd_o, 32-bit: reads accepted;
  - stat_wr_o, 32-bit: writes accepted;
  - stat_err_o, 16-bit: out-of-range accepted.
- Counters increment on acceptance, saturate at all-ones, reset to 0, and do not affect the datapath.
- When not defined, these ports and counters do not exist.

Test Plan:
- Write to 32'h1000 with data 32'hDEADBEEF, strobe 4'hF, then read 32'h1000:
  - write: mem_en_o=2'b01, mem_addr_o=0;
  - read: p_data_o=32'hDEADBEEF, p_error_o=0, p_valid_o 2 cycles after acceptance.
- Read 32'h1004 -> mem_en_o=2'b10, mem_addr_o=0. Read 32'h1008 -> mem_en_o=2'b01, mem_addr_o=1.
- Read 32'h0FFC and read 32'h21000:
  - mem_en_o=0 for both;
  - responses carry p_error_o=1 and p_data_o=0, in order.
- Issue 3 back-to-back reads with p_ready_i=0 -> q_ready_o drops after 2 acceptances. Raise p_ready_i -> the third read is accepted in the same cycle as the first pop.
- Write 32'h1000 with data 32'h11223344 and strobe 4'b0010 -> mem_be_o=4'b0010; the write response has p_data_o=0 and p_error_o=0.
- Assert rst_ni low with 2 reads in flight -> p_valid_o=0 and mem_en_o=0 immediately. After release, no stale responses appear and q_ready_o=1.
